// File: rtl/aes_stream_adapter_pkg.sv
// Shared types and constants for the AES stream adapter and its helpers.
package aes_package;

   localparam int AES_WORD_WIDTH      = 32;
   localparam int AES_BLOCK_WIDTH     = 128;
   localparam int AES_WORDS_PER_BLOCK = 4;

   // Job sequencing states of the adapter.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GATHER = 3'd1,
      ST_CIPHER = 3'd2,
      ST_EMIT   = 3'd3,
      ST_DONE   = 3'd4
   } aes_adapter_state_t;

endpackage

// File: rtl/aes_stream_adapter_if.sv
// Stream and cipher-core handshake bundle seen by the AES stream adapter.
// The slave modport is the adapter's view; master is the surrounding system.
interface aes_stream_adapter_if;
   import aes_package::*;

   logic                       pt_valid;
   logic                       pt_ready;
   logic [AES_WORD_WIDTH-1:0]  pt_data;
   logic                       core_req;
   logic                       core_ack;
   logic [AES_BLOCK_WIDTH-1:0] core_pt;
   logic [AES_BLOCK_WIDTH-1:0] core_ct;
   logic                       ct_valid;
   logic                       ct_ready;
   logic [AES_WORD_WIDTH-1:0]  ct_data;

   modport slave (
      input  pt_valid, pt_data, core_ack, core_ct, ct_ready,
      output pt_ready, core_req, core_pt, ct_valid, ct_data
   );

   modport master (
      output pt_valid, pt_data, core_ack, core_ct, ct_ready,
      input  pt_ready, core_req, core_pt, ct_valid, ct_data
   );

endinterface

// File: rtl/aes_stream_adapter_serializer.sv
// Splits a captured 128-bit block into 32-bit words on a valid/ready sink,
// word 0 (LSBs) first. Valid follows 'active' only, so once raised the word
// is held stable until the sink accepts it.
module aes_word_serializer #(
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [BLOCK_WIDTH-1:0] load_data,
   input  logic                   active,
   input  logic                   ct_ready,
   output logic                   ct_valid,
   output logic [DATA_WIDTH-1:0]  ct_data,
   output logic                   last_hs
);

   localparam int WPB   = BLOCK_WIDTH / DATA_WIDTH;
   localparam int IDX_W = $clog2(WPB);

   logic [BLOCK_WIDTH-1:0] ct_buf_r;
   logic [IDX_W-1:0]       word_cnt_r;
   logic                   hs_s;

   // Handshake decode and word select from the registered buffer.
   always_comb begin
      ct_valid = active;
      hs_s     = active & ct_ready;
      last_hs  = hs_s & (word_cnt_r == IDX_W'(WPB - 1));
      ct_data  = ct_buf_r[word_cnt_r * DATA_WIDTH +: DATA_WIDTH];
   end

   // Capture a fresh block or step to the next word on each accepted beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         ct_buf_r   <= {BLOCK_WIDTH{1'b0}};
         word_cnt_r <= {IDX_W{1'b0}};
      end else if (load) begin
         ct_buf_r   <= load_data;
         word_cnt_r <= {IDX_W{1'b0}};
      end else if (hs_s) begin
         word_cnt_r <= word_cnt_r + IDX_W'(1);
      end
   end

endmodule

// File: rtl/aes_stream_adapter.sv
// Engine-side adapter between HWPE streamers and an iterative AES core:
// gathers four plaintext words per block, hands the block to the core,
// then streams the ciphertext back out and pulses done after the last block.
module aes_stream_adapter
   import aes_package::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 128,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 enable,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] n_blocks,
   output logic                 busy,
   output logic                 done,
   aes_stream_adapter_if.slave  bus
);

   localparam int WPB   = BLOCK_WIDTH / DATA_WIDTH;
   localparam int IDX_W = $clog2(WPB);

   aes_adapter_state_t     state_r;
   aes_adapter_state_t     state_nxt_s;
   logic                   srst_s;
   logic                   start_acc_s;
   logic                   pt_hs_s;
   logic                   gather_last_s;
   logic                   emit_last_s;
   logic                   final_blk_s;
   logic [CNT_WIDTH-1:0]   nblk_r;
   logic [CNT_WIDTH-1:0]   block_cnt_r;
   logic [CNT_WIDTH-1:0]   last_blk_s;
   logic [IDX_W-1:0]       gather_cnt_r;
   logic [BLOCK_WIDTH-1:0] pt_buf_r;

   assign srst_s = reset | clear;

   // Handshake and end-of-block / end-of-job decode.
   always_comb begin
      pt_hs_s       = bus.pt_valid & bus.pt_ready;
      gather_last_s = (gather_cnt_r == IDX_W'(WPB - 1));
      last_blk_s    = nblk_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      final_blk_s   = (block_cnt_r == last_blk_s);
   end

   // Next-state decode; start is only honoured from IDLE with enable high.
   always_comb begin
      state_nxt_s = state_r;
      start_acc_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && enable) begin
               start_acc_s = 1'b1;
               if (n_blocks == {CNT_WIDTH{1'b0}}) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_GATHER;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GATHER: begin
            if (pt_hs_s && gather_last_s) begin
               state_nxt_s = ST_CIPHER;
            end else begin
               state_nxt_s = ST_GATHER;
            end
         end
         ST_CIPHER: begin
            if (bus.core_ack) begin
               state_nxt_s = ST_EMIT;
            end else begin
               state_nxt_s = ST_CIPHER;
            end
         end
         ST_EMIT: begin
            if (emit_last_s) begin
               if (final_blk_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_GATHER;
               end
            end else begin
               state_nxt_s = ST_EMIT;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register; reset and clear both return to IDLE.
   always_ff @(posedge clk) begin
      if (srst_s) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Job bookkeeping and plaintext packing (word 0 lands in the LSBs).
   always_ff @(posedge clk) begin
      if (srst_s) begin
         nblk_r       <= {CNT_WIDTH{1'b0}};
         block_cnt_r  <= {CNT_WIDTH{1'b0}};
         gather_cnt_r <= {IDX_W{1'b0}};
         pt_buf_r     <= {BLOCK_WIDTH{1'b0}};
      end else begin
         if (start_acc_s) begin
            nblk_r       <= n_blocks;
            block_cnt_r  <= {CNT_WIDTH{1'b0}};
            gather_cnt_r <= {IDX_W{1'b0}};
         end
         if (pt_hs_s) begin
            pt_buf_r[gather_cnt_r * DATA_WIDTH +: DATA_WIDTH] <= bus.pt_data;
            gather_cnt_r <= gather_cnt_r + IDX_W'(1);
         end
         if ((state_r == ST_EMIT) && emit_last_s && !final_blk_s) begin
            block_cnt_r <= block_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   // Outputs decoded from registered state; only pt_ready sees enable.
   always_comb begin
      bus.pt_ready = (state_r == ST_GATHER) & enable;
      bus.core_req = (state_r == ST_CIPHER);
      bus.core_pt  = pt_buf_r;
      busy         = (state_r != ST_IDLE);
      done         = (state_r == ST_DONE);
   end

   aes_word_serializer #(
      .DATA_WIDTH  (DATA_WIDTH),
      .BLOCK_WIDTH (BLOCK_WIDTH)
   ) u_serializer (
      .clk       (clk),
      .reset     (srst_s),
      .load      ((state_r == ST_CIPHER) & bus.core_ack),
      .load_data (bus.core_ct),
      .active    (state_r == ST_EMIT),
      .ct_ready  (bus.ct_ready),
      .ct_valid  (bus.ct_valid),
      .ct_data   (bus.ct_data),
      .last_hs   (emit_last_s)
   );

endmodule

// File: doc/aes_stream_adapter.md
# aes_stream_adapter

Engine-side responder to the AES HWPE control FSM and streamers. On `start` it consumes 32-bit plaintext words from the source stream, packs every four into a 128-bit block, and hands each block to the cipher core over a req/ack handshake. It then serialises each 128-bit ciphertext back onto the 32-bit sink stream and pulses `done` after the last block. It sits between the HWPE streamers and the iterative AES core.

## Interface

Parameters:
- `DATA_WIDTH`, 32: stream word width. Fixed at 32; other values are unsupported.
- `BLOCK_WIDTH`, 128: cipher block width. Gives `WORDS_PER_BLOCK` = 4.
- `CNT_WIDTH`, 8: width of the block counter and of `n_blocks`.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `clear`  in  1  synchronous soft clear; same effect as `reset`
- `enable`  in  1  gates `start` acceptance and `pt_ready`
- `start`  in  1  one-cycle job start pulse
- `n_blocks`  in  CNT_WIDTH  blocks to process; sampled on accepted `start`
- `pt_valid`  in  1  plaintext word valid
- `pt_ready`  out  1  plaintext word ready
- `pt_data`  in  32  plaintext word
- `core_req`  out  1  block request to cipher core
- `core_ack`  in  1  core result valid / request accepted
- `core_pt`  out  128  packed plaintext block
- `core_ct`  in  128  ciphertext block; valid when `core_ack`=1
- `ct_valid`  out  1  ciphertext word valid
- `ct_ready`  in  1  ciphertext word ready
- `ct_data`  out  32  ciphertext word
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle completion pulse

## Operation

- States: IDLE, GATHER, CIPHER, EMIT, DONE. Reset or clear forces IDLE, zeroes all counters and both 128-bit buffers, and drives every output to 0.
- **IDLE**
  - Accepts `start` only when `start`=1 and `enable`=1; latches `n_blocks`.
  - `n_blocks`=0 → DONE. Otherwise → GATHER with `word_cnt`=0 and `block_cnt`=0.
- **GATHER**
  - `pt_ready` = `enable`.
  - Each handshake (`pt_valid` and `pt_ready`) writes `pt_data` into `pt_buf[32*word_cnt +: 32]` and increments `word_cnt`; word 0 is the LSBs.
  - The 4th handshake → CIPHER, with `word_cnt` wrapping to 0.
- **CIPHER**
  - `core_req`=1, `core_pt`=`pt_buf`, both held stable until `core_ack`.
  - On `core_ack`: capture `core_ct` into `ct_buf`, → EMIT.
  - `core_ack` in any other state is ignored.
- **EMIT**
  - `ct_valid`=1 and `ct_data`=`ct_buf[32*word_cnt +: 32]`.
  - Not gated by `enable`: once raised, `ct_valid` and `ct_data` stay stable until the handshake.
  - On the 4th handshake: if `block_cnt` = latched `n_blocks`−1 → DONE; else increment `block_cnt` and → GATHER.
- **DONE**: `done`=1 for exactly one cycle, then → IDLE.
- `start` outside IDLE is ignored. `n_blocks` changes after acceptance have no effect.
- Widths: `word_cnt` is 2 bits and wraps naturally. `block_cnt` is CNT_WIDTH bits. The end-of-job comparison uses the latched value, so `n_blocks`=255 processes 255 blocks.

## Timing

- All outputs decode from registered state and buffers. No input→output combinational paths except:
  - `pt_ready` depends on `enable`;
  - `ct_valid` and `ct_data` are stable through EMIT.
- Cycle-level sequence:
  - `start` accepted at cycle 0 → GATHER at cycle 1, `pt_ready`=1 at cycle 1.
  - Back-to-back words at cycles 1–4 → `core_req`=1 at cycle 5.
  - `core_ack` at cycle k → `ct_valid`=1 at k+1.
  - Back-to-back sink handshakes at k+1..k+4 → `done` at k+5, IDLE at k+6 (`busy` low).
- Minimum job overhead: 2 cycles (`start`→GATHER, DONE→IDLE). Per block: 4 + 1 + core latency + 4 cycles.
- `core_ack` in the same cycle `core_req` first rises is legal; EMIT follows the next cycle.
- `reset` or `clear` mid-job: the next cycle is IDLE with `core_req`, `ct_valid`, `pt_ready` and `done` all 0. Partially gathered or emitted words are discarded.
- `reset` and `clear` asserted together behave identically to `reset` alone.

## Structure

- Shared package `aes_package`:
  - `aes_adapter_state_t`, an enum of the five states;
  - constants `AES_WORD_WIDTH`=32, `AES_BLOCK_WIDTH`=128, `AES_WORDS_PER_BLOCK`=4.
- The module is a single block. A natural sub-module is `aes_word_serializer`: the 128→32 mux plus `word_cnt` and the valid/ready logic for EMIT, reusable by the sink side of other engines.

## Test plan

- **Single block.** `n_blocks`=1; plaintext 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  → `core_pt` = 0x0F0E0D0C_0B0A0908_07060504_03020100.
  Core returns 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A after 3 cycles.
  → `ct_data` sequence 0x70B4C55A, 0xD8CDB780, 0x6A7B0430, 0x69C4E0D8, then a single `done` pulse.
- **Two blocks, back-pressure.** `n_blocks`=2; random `pt_valid` and `ct_ready` with a 50% duty cycle.
  → exactly 8 words in and 8 out, in order; `ct_data` is stable whenever `ct_valid` is high and `ct_ready` low; `done` only after the 8th sink handshake.
- **Zero blocks.** `n_blocks`=0 → `done` at cycle 1; `pt_ready` and `core_req` never rise.
- **Enable and start gating.**
  - `start` with `enable`=0 → stays IDLE.
  - `enable` dropped after 2 words → `pt_ready`=0; gathering resumes at word 2 when `enable` returns.
  - `start` during EMIT → ignored.
- **Clear mid-CIPHER.** Assert `clear` while `core_req`=1 → next cycle all outputs are 0 and state is IDLE. A following job with `n_blocks`=1 completes correctly with fresh data.
